efuse_array_mgr: RTL

- Parametrised eFuse array manager; next generation of the single-word eFuse main FSM.
- Manages NUM_WORDS words of DATA_W bits behind one eFuse controller.
- After reset, scans every word into a shadow register bank, then serves per-word program requests with a blank check, a busy/ack/error handshake and a bypass override.
- Sits between the register decoder and the eFuse macro controller.

---
 rtl/efuse_pkg.sv | 20 ++
 rtl/efuse_shadow_bank.sv | 34 +++
 rtl/efuse_array_mgr.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/efuse_pkg.sv
// Shared definitions for the eFuse array manager: FSM states, error codes
// and default geometry.
package efuse_pkg;

  localparam int DEFAULT_DATA_W    = 32;
  localparam int DEFAULT_NUM_WORDS = 4;

  typedef enum logic [1:0] {
    SCAN   = 2'd0,
    READY  = 2'd1,
    PGM    = 2'd2,
    REREAD = 2'd3
  } efuseState_e;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_NOT_BLANK = 2'b01;
  localparam logic [1:0] ERR_REJECT    = 2'b10;
  localparam logic [1:0] ERR_VERIFY    = 2'b11;

endpackage

// File: rtl/efuse_shadow_bank.sv
// NUM_WORDS x DATA_W shadow copy of the fuse array: one write port, every
// word visible at once on a flat read-out bus.
module efuse_shadow_bank
  import efuse_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int NUM_WORDS = DEFAULT_NUM_WORDS,
  parameter int ADDR_W    = $clog2(NUM_WORDS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we_i,
  input  logic [ADDR_W-1:0]             waddr_i,
  input  logic [DATA_W-1:0]             wdata_i,
  output logic [NUM_WORDS*DATA_W-1:0]   rdata_o
);

  logic [DATA_W-1:0] mem_q [NUM_WORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  for (genvar g = 0; g < NUM_WORDS; g++) begin : gen_flat
    assign rdata_o[g*DATA_W +: DATA_W] = mem_q[g];
  end

endmodule

// File: rtl/efuse_array_mgr.sv
// eFuse array manager: scans all words into a shadow bank after reset, then
// serves write-once program requests. Build option EFUSE_PGM_VERIFY_EN adds
// a read-back compare after each burn.
module efuse_array_mgr
  import efuse_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int NUM_WORDS = DEFAULT_NUM_WORDS,
  parameter int ADDR_W    = $clog2(NUM_WORDS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          efuse_bypass_i,
  input  logic [NUM_WORDS*DATA_W-1:0]   bypass_data_i,
  input  logic                          pgm_req_i,
  input  logic [ADDR_W-1:0]             pgm_addr_i,
  input  logic [DATA_W-1:0]             pgm_data_i,
  output logic                          pgm_busy_o,
  output logic                          pgm_ack_o,
  output logic                          pgm_err_o,
  output logic [1:0]                    pgm_err_code_o,
  output logic [NUM_WORDS*DATA_W-1:0]   efuse_out_o,
  output logic                          efuse_valid_o,
  output logic                          ctrl_read_o,
  output logic                          ctrl_write_o,
  output logic [ADDR_W-1:0]             ctrl_addr_o,
  output logic [DATA_W-1:0]             ctrl_wdata_o,
  input  logic                          ctrl_rd_done_i,
  input  logic                          ctrl_wr_done_i,
  input  logic [DATA_W-1:0]             ctrl_rdata_i
);

  efuseState_e                  state_q, state_d;
  logic [ADDR_W-1:0]            scanIdx_q, scanIdx_d;
  logic [ADDR_W-1:0]            pgmAddr_q, pgmAddr_d;
  logic [DATA_W-1:0]            pgmData_q, pgmData_d;
  logic [ADDR_W-1:0]            ctrlAddr_q, ctrlAddr_d;
  logic [DATA_W-1:0]            ctrlWdata_q, ctrlWdata_d;
  logic                         ctrlRead_q, ctrlRead_d;
  logic                         ctrlWrite_q, ctrlWrite_d;
  logic                         busy_q, busy_d;
  logic                         ack_q, ack_d;
  logic                         err_q, err_d;
  logic [1:0]                   errCode_q, errCode_d;
  logic                         valid_q, valid_d;
  logic                         reqPrev_q;
  logic [NUM_WORDS*DATA_W-1:0]  efuseOut_q;

  logic [NUM_WORDS*DATA_W-1:0]  shadowFlat;
  logic                         shadowWe;
  logic [ADDR_W-1:0]            shadowWaddr;
  logic                         reqEdge;
  logic                         rdDone;
  logic                         wrDone;
  logic                         addrInRange;
  logic [DATA_W-1:0]            targetWord;

  // Done pulses only count while the matching request is actually on the bus.
  assign reqEdge     = pgm_req_i & ~reqPrev_q;
  assign rdDone      = ctrl_rd_done_i & ctrlRead_q & ((state_q == SCAN) || (state_q == REREAD));
  assign wrDone      = ctrl_wr_done_i & ctrlWrite_q & (state_q == PGM);
  assign addrInRange = (int'(pgm_addr_i) < NUM_WORDS);
  assign targetWord  = addrInRange ? shadowFlat[pgm_addr_i*DATA_W +: DATA_W] : '0;
  assign shadowWe    = rdDone;
  assign shadowWaddr = (state_q == SCAN) ? scanIdx_q : pgmAddr_q;

  efuse_shadow_bank #(
    .DATA_W    (DATA_W),
    .NUM_WORDS (NUM_WORDS),
    .ADDR_W    (ADDR_W)
  ) u_shadow (
    .clk     (clk),
    .rst     (rst),
    .we_i    (shadowWe),
    .waddr_i (shadowWaddr),
    .wdata_i (ctrl_rdata_i),
    .rdata_o (shadowFlat)
  );

  always_comb begin
    state_d     = state_q;
    scanIdx_d   = scanIdx_q;
    pgmAddr_d   = pgmAddr_q;
    pgmData_d   = pgmData_q;
    ctrlAddr_d  = ctrlAddr_q;
    ctrlWdata_d = ctrlWdata_q;
    ctrlRead_d  = 1'b0;
    ctrlWrite_d = 1'b0;
    busy_d      = busy_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    errCode_d   = errCode_q;
    valid_d     = valid_q;

    case (state_q)
      SCAN: begin
        ctrlRead_d = 1'b1;
        ctrlAddr_d = scanIdx_q;
        if (rdDone) begin
          if (scanIdx_q == ADDR_W'(NUM_WORDS - 1)) begin
            ctrlRead_d = 1'b0;
            valid_d    = 1'b1;
            state_d    = READY;
          end else begin
            scanIdx_d  = scanIdx_q + ADDR_W'(1);
            ctrlAddr_d = scanIdx_q + ADDR_W'(1);
          end
        end
      end

      READY: begin
        if (reqEdge) begin
          if (efuse_bypass_i || !addrInRange) begin
            err_d     = 1'b1;
            errCode_d = ERR_REJECT;
          end else if (targetWord != '0) begin
            err_d     = 1'b1;
            errCode_d = ERR_NOT_BLANK;
          end else begin
            pgmAddr_d = pgm_addr_i;
            pgmData_d = pgm_data_i;
            busy_d    = 1'b1;
            state_d   = PGM;
          end
        end
      end

      PGM: begin
        ctrlWrite_d = 1'b1;
        ctrlAddr_d  = pgmAddr_q;
        ctrlWdata_d = pgmData_q;
        if (wrDone) begin
          ctrlWrite_d = 1'b0;
          state_d     = REREAD;
        end
      end

      REREAD: begin
        ctrlRead_d = 1'b1;
        ctrlAddr_d = pgmAddr_q;
        if (rdDone) begin
          ctrlRead_d = 1'b0;
          busy_d     = 1'b0;
          state_d    = READY;
`ifdef EFUSE_PGM_VERIFY_EN
          if (ctrl_rdata_i != pgmData_q) begin
            err_d     = 1'b1;
            errCode_d = ERR_VERIFY;
          end else begin
            ack_d     = 1'b1;
            errCode_d = ERR_NONE;
          end
`else
          ack_d     = 1'b1;
          errCode_d = ERR_NONE;
`endif
        end
      end

      default: state_d = SCAN;
    endcase

    // A request outside READY is turned away without touching the active access.
    if (reqEdge && (state_q != READY)) begin
      err_d     = 1'b1;
      errCode_d = ERR_REJECT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SCAN;
      scanIdx_q   <= '0;
      pgmAddr_q   <= '0;
      pgmData_q   <= '0;
      ctrlAddr_q  <= '0;
      ctrlWdata_q <= '0;
      ctrlRead_q  <= 1'b0;
      ctrlWrite_q <= 1'b0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      errCode_q   <= ERR_NONE;
      valid_q     <= 1'b0;
      reqPrev_q   <= 1'b0;
      efuseOut_q  <= '0;
    end else begin
      state_q     <= state_d;
      scanIdx_q   <= scanIdx_d;
      pgmAddr_q   <= pgmAddr_d;
      pgmData_q   <= pgmData_d;
      ctrlAddr_q  <= ctrlAddr_d;
      ctrlWdata_q <= ctrlWdata_d;
      ctrlRead_q  <= ctrlRead_d;
      ctrlWrite_q <= ctrlWrite_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      errCode_q   <= errCode_d;
      valid_q     <= valid_d;
      reqPrev_q   <= pgm_req_i;
      efuseOut_q  <= efuse_bypass_i ? bypass_data_i : shadowFlat;
    end
  end

  assign pgm_busy_o     = busy_q;
  assign pgm_ack_o      = ack_q;
  assign pgm_err_o      = err_q;
  assign pgm_err_code_o = errCode_q;
  assign efuse_out_o    = efuseOut_q;
  assign efuse_valid_o  = valid_q;
  assign ctrl_read_o    = ctrlRead_q;
  assign ctrl_write_o   = ctrlWrite_q;
  assign ctrl_addr_o    = ctrlAddr_q;
  assign ctrl_wdata_o   = ctrlWdata_q;

endmodule
